// File: rtl/pulse_shaper_pkg.sv
// Shared definitions for the polyphase pulse shaper: symbol encoding, FSM
// encoding, the default RRC coefficient table and accumulator sizing.
package pulse_shaper_pkg;

  localparam logic [1:0] SYM_ZERO = 2'b00;
  localparam logic [1:0] SYM_POS  = 2'b01;
  localparam logic [1:0] SYM_NEG  = 2'b11;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_CALC_I = 2'b01;
  localparam logic [1:0] ST_CALC_Q = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    CALC_I = ST_CALC_I,
    CALC_Q = ST_CALC_Q
  } state_e;

  localparam int unsigned DEF_OSR    = 4;
  localparam int unsigned DEF_NTAPS  = 17;
  localparam int unsigned DEF_COEF_W = 14;

  // Row-major by phase: index = phase*NTAPS + tap.
  localparam logic signed [DEF_COEF_W-1:0] DEFAULT_COEFS [DEF_OSR*DEF_NTAPS] = '{
    -14'sd23,   14'sd15,    14'sd8,    -14'sd51,   14'sd107,  -14'sd169,
     14'sd225, -14'sd264,   14'sd4716, -14'sd264,  14'sd225,  -14'sd169,
     14'sd107, -14'sd51,    14'sd8,     14'sd15,  -14'sd23,
     14'sd6,   -14'sd20,    14'sd24,   -14'sd10,  -14'sd60,    14'sd190,
    -14'sd520,  14'sd1720,  14'sd4010, -14'sd790,  14'sd390,  -14'sd210,
     14'sd96,  -14'sd30,   -14'sd12,    14'sd22,  -14'sd18,
     14'sd24,  -14'sd22,   -14'sd2,     14'sd64,  -14'sd190,   14'sd450,
    -14'sd1010, 14'sd2850,  14'sd2850, -14'sd1010, 14'sd450,  -14'sd190,
     14'sd64,  -14'sd2,    -14'sd22,    14'sd24,   14'sd0,
    -14'sd18,   14'sd22,   -14'sd12,   -14'sd30,   14'sd96,   -14'sd210,
     14'sd390, -14'sd790,   14'sd4010,  14'sd1720, -14'sd520,   14'sd190,
    -14'sd60,  -14'sd10,    14'sd24,   -14'sd20,   14'sd6
  };

  function automatic int unsigned acc_width(input int unsigned coef_w,
                                            input int unsigned ntaps);
    return coef_w + $clog2(ntaps);
  endfunction

endpackage

// File: rtl/pulse_shaper_tapsum.sv
// Combinational tap-sum for one polyphase branch over a ternary symbol history.
module pulse_shaper_tapsum
  import pulse_shaper_pkg::*;
#(
  parameter int unsigned NTAPS  = 17,
  parameter int unsigned OSR    = 4,
  parameter int unsigned COEF_W = 14,
  parameter logic signed [COEF_W-1:0] COEFS [OSR*NTAPS] = DEFAULT_COEFS,
  localparam int unsigned PH_W  = $clog2(OSR),
  localparam int unsigned ACC_W = acc_width(COEF_W, NTAPS)
) (
  input  logic [2*NTAPS-1:0]       hist,
  input  logic [PH_W-1:0]          phase,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [COEF_W-1:0] row [NTAPS];

  // Constant-index row select keeps the coefficient table a plain mux.
  always_comb begin
    for (int unsigned t = 0; t < NTAPS; t++) row[t] = '0;
    for (int unsigned p = 0; p < OSR; p++) begin
      if (phase == PH_W'(p)) begin
        for (int unsigned t = 0; t < NTAPS; t++) row[t] = COEFS[p*NTAPS + t];
      end
    end
  end

  always_comb begin
    acc = '0;
    for (int unsigned t = 0; t < NTAPS; t++) begin
      case (hist[2*t +: 2])
        SYM_POS: acc = acc + ACC_W'(row[t]);
        SYM_NEG: acc = acc - ACC_W'(row[t]);
        default: acc = acc;
      endcase
    end
  end

endmodule

// File: rtl/pulse_shaper_interp.sv
// Polyphase interpolating pulse shaper: ternary I/Q symbols in, rounded and
// saturated OUT_W-bit I/Q samples out, one pair per ENABLE tick.
module pulse_shaper_interp
  import pulse_shaper_pkg::*;
#(
  parameter int unsigned NTAPS  = 17,
  parameter int unsigned OSR    = 4,
  parameter int unsigned COEF_W = 14,
  parameter int unsigned OUT_W  = 13,
  parameter int unsigned SHIFT  = 1,
  parameter logic signed [COEF_W-1:0] COEFS [OSR*NTAPS] = DEFAULT_COEFS
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       ENABLE,
  input  logic                       SYM_VALID,
  input  logic [1:0]                 SYM_I,
  input  logic [1:0]                 SYM_Q,
  output logic                       SYM_READY,
  output logic signed [OUT_W-1:0]    OUTPUT_I,
  output logic signed [OUT_W-1:0]    OUTPUT_Q,
  output logic                       OUT_VALID,
  output logic [$clog2(OSR)-1:0]     OUT_PHASE,
  output logic                       UNDERFLOW,
  output logic                       OVERRUN
);

  localparam int unsigned PH_W  = $clog2(OSR);
  localparam int unsigned ACC_W = acc_width(COEF_W, NTAPS);
  localparam int unsigned RW    = ACC_W + 1;

  localparam logic signed [RW-1:0] Y_MAX = RW'(2**(OUT_W-1) - 1);
  localparam logic signed [RW-1:0] Y_MIN = ~Y_MAX;

  if (OSR < 2 || (OSR & (OSR - 1)) != 0) begin : g_bad_osr
    $error("pulse_shaper_interp: OSR must be a power of two >= 2");
  end
  if (NTAPS < 2 || OUT_W >= RW || SHIFT >= ACC_W) begin : g_bad_width
    $error("pulse_shaper_interp: inconsistent NTAPS/OUT_W/SHIFT");
  end

  state_e                   state;
  logic [PH_W-1:0]          phase;
  logic [PH_W-1:0]          pphase;
  logic [2*NTAPS-1:0]       hist_i;
  logic [2*NTAPS-1:0]       hist_q;
  logic [2*NTAPS-1:0]       hist_sel;
  logic signed [ACC_W-1:0]  acc;
  logic signed [RW-1:0]     acc_x;
  logic signed [RW-1:0]     rnd;
  logic signed [OUT_W-1:0]  y;
  logic signed [OUT_W-1:0]  y_i_r;
  logic [1:0]               new_i;
  logic [1:0]               new_q;

  assign SYM_READY = (state == IDLE) && ENABLE && (phase == '0);
  assign new_i     = SYM_VALID ? SYM_I : SYM_ZERO;
  assign new_q     = SYM_VALID ? SYM_Q : SYM_ZERO;

  // One tap-sum unit, time-shared: I history in CALC_I, Q history in CALC_Q.
  assign hist_sel = (state == CALC_Q) ? hist_q : hist_i;

  pulse_shaper_tapsum #(
    .NTAPS  (NTAPS),
    .OSR    (OSR),
    .COEF_W (COEF_W),
    .COEFS  (COEFS)
  ) u_tapsum (
    .hist  (hist_sel),
    .phase (pphase),
    .acc   (acc)
  );

  // One guard bit so the rounding offset cannot wrap the accumulator.
  assign acc_x = RW'(acc);

  if (SHIFT > 0) begin : g_round
    localparam logic signed [RW-1:0] HALF = RW'(1) << (SHIFT - 1);
    assign rnd = (acc_x + HALF) >>> SHIFT;
  end else begin : g_noround
    assign rnd = acc_x;
  end

  always_comb begin
    if (rnd > Y_MAX)      y = Y_MAX[OUT_W-1:0];
    else if (rnd < Y_MIN) y = Y_MIN[OUT_W-1:0];
    else                  y = rnd[OUT_W-1:0];
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      phase     <= '0;
      pphase    <= '0;
      hist_i    <= '0;
      hist_q    <= '0;
      y_i_r     <= '0;
      OUTPUT_I  <= '0;
      OUTPUT_Q  <= '0;
      OUT_PHASE <= '0;
      OUT_VALID <= 1'b0;
      UNDERFLOW <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      OUT_VALID <= 1'b0;
      case (state)
        IDLE: begin
          if (ENABLE) begin
            state  <= CALC_I;
            pphase <= phase;
            phase  <= phase + PH_W'(1);
            if (SYM_READY) begin
              hist_i <= {hist_i[2*NTAPS-3:0], new_i};
              hist_q <= {hist_q[2*NTAPS-3:0], new_q};
              if (!SYM_VALID) UNDERFLOW <= 1'b1;
            end
          end
        end
        CALC_I: begin
          y_i_r <= y;
          state <= CALC_Q;
          if (ENABLE) OVERRUN <= 1'b1;
        end
        CALC_Q: begin
          OUTPUT_I  <= y_i_r;
          OUTPUT_Q  <= y;
          OUT_PHASE <= pphase;
          OUT_VALID <= 1'b1;
          state     <= IDLE;
          if (ENABLE) OVERRUN <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_shaper_interp.sv
// Directed bench for pulse_shaper_interp: default instance (SHIFT=1) and a
// SHIFT=0 instance share stimulus so rounding and saturation are seen together.
module tb_pulse_shaper_interp;

  logic        CLK = 1'b0;
  logic        RESET, ENABLE, SYM_VALID;
  logic [1:0]  SYM_I, SYM_Q;

  logic              rdy_a, val_a, unf_a, ovr_a;
  logic signed [12:0] i_a, q_a;
  logic [1:0]        ph_a;
  logic              rdy_b, val_b, unf_b, ovr_b;
  logic signed [12:0] i_b, q_b;
  logic [1:0]        ph_b;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  pulse_shaper_interp dut_a (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .SYM_VALID(SYM_VALID),
    .SYM_I(SYM_I), .SYM_Q(SYM_Q), .SYM_READY(rdy_a),
    .OUTPUT_I(i_a), .OUTPUT_Q(q_a), .OUT_VALID(val_a), .OUT_PHASE(ph_a),
    .UNDERFLOW(unf_a), .OVERRUN(ovr_a)
  );

  pulse_shaper_interp #(.SHIFT(0)) dut_b (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .SYM_VALID(SYM_VALID),
    .SYM_I(SYM_I), .SYM_Q(SYM_Q), .SYM_READY(rdy_b),
    .OUTPUT_I(i_b), .OUTPUT_Q(q_b), .OUT_VALID(val_b), .OUT_PHASE(ph_b),
    .UNDERFLOW(unf_b), .OVERRUN(ovr_b)
  );

  typedef struct {
    logic       v;
    logic [1:0] si;
    logic [1:0] sq;
    logic       rdy;
    int         ph;
    logic       chk;
    int         ei;
    int         eq;
    int         ei0;
    int         eq0;
  } vec_t;

  localparam int NV = 172;
  vec_t tv [NV];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_exp(input int n, input int ei, input int eq,
                         input int ei0, input int eq0);
    tv[n].chk = 1'b1;
    tv[n].ei  = ei;
    tv[n].eq  = eq;
    tv[n].ei0 = ei0;
    tv[n].eq0 = eq0;
  endtask

  // Pulse ENABLE once and return the number of edges until OUT_VALID.
  task automatic issue(input logic v, input logic [1:0] si, input logic [1:0] sq,
                       input logic exp_rdy, output int lat);
    ENABLE = 1'b1; SYM_VALID = v; SYM_I = si; SYM_Q = sq;
    #1;
    chk("sym_ready", int'(rdy_a), int'(exp_rdy));
    @(posedge CLK); #1;
    ENABLE = 1'b0; SYM_VALID = 1'b0; SYM_I = 2'b00; SYM_Q = 2'b00;
    lat = 1;
    while (!val_a && lat < 8) begin
      @(posedge CLK); #1;
      lat++;
    end
  endtask

  initial begin
    int n, lat, cnt, cap_i, cap_q, cap_ph;

    RESET = 1'b1; ENABLE = 1'b0; SYM_VALID = 1'b0; SYM_I = 2'b00; SYM_Q = 2'b00;

    // Impulse: one +1 on I, then zeros; 9 symbol periods of 4 phases.
    n = 0;
    for (int m = 0; m < 9; m++) begin
      for (int p = 0; p < 4; p++) begin
        tv[n].v   = (p == 0);
        tv[n].si  = (m == 0 && p == 0) ? 2'b01 : 2'b00;
        tv[n].sq  = 2'b00;
        tv[n].rdy = (p == 0);
        tv[n].ph  = p;
        tv[n].chk = 1'b0;
        n++;
      end
    end
    // 17 periods of I=+1/Q=-1, then 17 periods of I=-1/Q=+1.
    for (int blk = 0; blk < 2; blk++) begin
      for (int m = 0; m < 17; m++) begin
        for (int p = 0; p < 4; p++) begin
          tv[n].v   = (p == 0);
          tv[n].si  = (p != 0) ? 2'b00 : (blk == 0) ? 2'b01 : 2'b11;
          tv[n].sq  = (p != 0) ? 2'b00 : (blk == 0) ? 2'b11 : 2'b01;
          tv[n].rdy = (p == 0);
          tv[n].ph  = p;
          tv[n].chk = 1'b0;
          n++;
        end
      end
    end
    set_exp(0,    -11,     0,   -23,     0);
    set_exp(4,      8,     0,    15,     0);
    set_exp(12,   -25,     0,   -51,     0);
    set_exp(28,  -132,     0,  -264,     0);
    set_exp(32,  2358,     0,  4095,     0);
    set_exp(96,  2218, -2217,  4095, -4096);
    set_exp(100, 2206, -2206,  4095, -4096);
    set_exp(164,-2229,  2229, -4096,  4095);
    set_exp(168,-2206,  2206, -4096,  4095);

    repeat (3) @(posedge CLK);
    #1;
    chk("rst_out_i", int'(i_a), 0);
    chk("rst_out_q", int'(q_a), 0);
    chk("rst_phase", int'(ph_a), 0);
    chk("rst_valid", int'(val_a), 0);
    chk("rst_underflow", int'(unf_a), 0);
    chk("rst_overrun", int'(ovr_a), 0);
    chk("rst_ready", int'(rdy_a), 0);
    RESET = 1'b0;

    for (int k = 0; k < NV; k++) begin
      issue(tv[k].v, tv[k].si, tv[k].sq, tv[k].rdy, lat);
      chk("latency", lat, 3);
      chk("out_phase", int'(ph_a), tv[k].ph);
      if (tv[k].chk) begin
        chk("out_i", int'(i_a), tv[k].ei);
        chk("out_q", int'(q_a), tv[k].eq);
        chk("sat_out_i", int'(i_b), tv[k].ei0);
        chk("sat_out_q", int'(q_b), tv[k].eq0);
      end
      @(posedge CLK); #1;
      chk("strobe_len", int'(val_a), 0);
    end
    chk("no_underflow", int'(unf_a), 0);
    chk("no_overrun", int'(ovr_a), 0);

    // Underflow at phase 0: zero symbol shifted into tap 0.
    issue(1'b0, 2'b01, 2'b01, 1'b1, lat);
    chk("uf_latency", lat, 3);
    chk("uf_flag", int'(unf_a), 1);
    chk("uf_out_i", int'(i_a), -2217);
    chk("uf_out_q", int'(q_a), 2218);
    chk("uf_sat_i", int'(i_b), -4096);
    @(posedge CLK); #1;
    for (int p = 1; p < 4; p++) begin
      issue(1'b0, 2'b00, 2'b00, 1'b0, lat);
      chk("uf_fill_phase", int'(ph_a), p);
      @(posedge CLK); #1;
    end
    chk("uf_sticky", int'(unf_a), 1);
    chk("ov_before", int'(ovr_a), 0);

    // Overrun: ENABLE held for two consecutive cycles.
    ENABLE = 1'b1; SYM_VALID = 1'b1; SYM_I = 2'b00; SYM_Q = 2'b00;
    #1;
    chk("ov_ready_first", int'(rdy_a), 1);
    @(posedge CLK); #1;
    chk("ov_ready_second", int'(rdy_a), 0);
    @(posedge CLK); #1;
    ENABLE = 1'b0; SYM_VALID = 1'b0;
    cnt = 0; cap_i = 0; cap_q = 0; cap_ph = -1;
    for (int c = 0; c < 8; c++) begin
      if (val_a) begin
        cnt++;
        cap_i = int'(i_a); cap_q = int'(q_a); cap_ph = int'(ph_a);
      end
      @(posedge CLK); #1;
    end
    chk("ov_strobes", cnt, 1);
    chk("ov_phase", cap_ph, 0);
    chk("ov_out_i", cap_i, -2210);
    chk("ov_out_q", cap_q, 2210);
    chk("ov_flag", int'(ovr_a), 1);
    issue(1'b1, 2'b00, 2'b00, 1'b0, lat);
    chk("ov_next_phase", int'(ph_a), 1);
    @(posedge CLK); #1;

    // Reset asserted while the pair is in CALC_Q.
    ENABLE = 1'b1;
    #1;
    @(posedge CLK); #1;
    ENABLE = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b1;
    @(posedge CLK); #1;
    chk("midrst_valid", int'(val_a), 0);
    chk("midrst_out_i", int'(i_a), 0);
    chk("midrst_out_q", int'(q_a), 0);
    chk("midrst_phase", int'(ph_a), 0);
    chk("midrst_underflow", int'(unf_a), 0);
    chk("midrst_overrun", int'(ovr_a), 0);
    RESET = 1'b0;
    cnt = 0;
    for (int c = 0; c < 4; c++) begin
      if (val_a) cnt++;
      @(posedge CLK); #1;
    end
    chk("midrst_no_strobe", cnt, 0);
    issue(1'b1, 2'b01, 2'b11, 1'b1, lat);
    chk("post_rst_latency", lat, 3);
    chk("post_rst_phase", int'(ph_a), 0);
    chk("post_rst_out_i", int'(i_a), -11);
    chk("post_rst_out_q", int'(q_a), 12);
    @(posedge CLK); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
